axi4_lite_read_slave: RTL and testbench



---
 rtl/axi4_lite_pkg.sv | 23 ++
 rtl/axi4_lite_read_slave_if.sv | 31 +++
 rtl/axi4_lite_reg_bank.sv | 38 +++
 rtl/axi4_lite_read_slave.sv | 133 +++++++++++++
 tb/tb_axi4_lite_read_slave.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi4_lite_pkg: response encodings, FSM states, shared helpers.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_read_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi4_lite_read_slave_if: AXI4-Lite AR and R channel bundle.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface axi4_lite_read_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;

  modport master (
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output ARREADY, RVALID, RDATA, RRESP
  );

endinterface
`default_nettype wire

// File: rtl/axi4_lite_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi4_lite_reg_bank: register storage, one write / one async read port.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 8,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  wr_en_i,
  input  wire logic [IDX_W-1:0]      wr_idx_i,
  input  wire logic [DATA_WIDTH-1:0] wr_data_i,
  input  wire logic [IDX_W-1:0]      rd_idx_i,
  output logic      [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] bank_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      bank_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Combinational read sees the pre-edge contents, giving read-before-write.
  assign rd_data_o = bank_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/axi4_lite_read_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi4_lite_read_slave: AXI4-Lite read responder over a local reg bank. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module axi4_lite_read_slave
  import axi4_lite_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 8,
  parameter  bit PRIV_ONLY  = 1'b0,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  wire logic                  ACLK,
  input  wire logic                  ARESET,
  axi4_lite_read_slave_if.slave      s_axi,
  input  wire logic                  wr_en,
  input  wire logic [IDX_W-1:0]      wr_idx,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  output logic      [15:0]           rd_count
);

  localparam int BYTE_LSB = $clog2(DATA_WIDTH / 8);
  localparam int IDX_HI   = BYTE_LSB + IDX_W;

  state_e                state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [15:0]           rd_count_q, rd_count_d;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic                  w_priv_err;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_bank_data;

  assign w_ar_hs = s_axi.ARVALID & arready_q;
  assign w_r_hs  = rvalid_q & s_axi.RREADY;

  assign w_idx        = s_axi.ARADDR[IDX_HI-1:BYTE_LSB];
  assign w_misaligned = |s_axi.ARADDR[BYTE_LSB-1:0];
  assign w_priv_err   = PRIV_ONLY && !s_axi.ARPROT[0];

  generate
    if (IDX_HI < ADDR_WIDTH) begin : g_range_check
      assign w_out_of_range = |s_axi.ARADDR[ADDR_WIDTH-1:IDX_HI];
    end else begin : g_range_full
      assign w_out_of_range = 1'b0;
    end
  endgenerate

  assign w_err = w_misaligned | w_out_of_range | w_priv_err;

  axi4_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_bank (
    .clk       (ACLK),
    .rst       (ARESET),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data),
    .rd_idx_i  (w_idx),
    .rd_data_o (w_bank_data)
  );

  always_comb begin
    state_d    = state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_count_d = rd_count_q;
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (w_ar_hs) begin
          state_d   = RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = w_err ? '0 : w_bank_data;
          rresp_d   = resp_of(w_err);
        end
      end
      RESP: begin
        // Response is frozen until accepted; bank writes do not reach rdata_q.
        if (w_r_hs) begin
          state_d    = IDLE;
          arready_d  = 1'b1;
          rvalid_d   = 1'b0;
          rd_count_d = rd_count_q + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
  assign rd_count      = rd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_read_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi4_lite_read_slave: scoreboard bench for the AXI4-Lite reader.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_axi4_lite_read_slave;
  import axi4_lite_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        wr0_en, wr1_en;
  logic [2:0]  wr0_idx, wr1_idx;
  logic [31:0] wr0_data, wr1_data;
  logic [15:0] rd0_count, rd1_count;

  exp_t        sb[$];
  logic [31:0] mbank[8];
  int          exp_count;
  int          checks;
  int          failures;

  always #5 ACLK = ~ACLK;

  axi4_lite_read_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0 ();
  axi4_lite_read_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1 ();

  axi4_lite_read_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .PRIV_ONLY(1'b0)
  ) u_dut0 (
    .ACLK(ACLK), .ARESET(ARESET), .s_axi(m0),
    .wr_en(wr0_en), .wr_idx(wr0_idx), .wr_data(wr0_data), .rd_count(rd0_count)
  );

  axi4_lite_read_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .PRIV_ONLY(1'b1)
  ) u_dut1 (
    .ACLK(ACLK), .ARESET(ARESET), .s_axi(m1),
    .wr_en(wr1_en), .wr_idx(wr1_idx), .wr_data(wr1_data), .rd_count(rd1_count)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic bank_write(input logic [2:0] idx, input logic [31:0] data);
    wr0_en   = 1'b1;
    wr0_idx  = idx;
    wr0_data = data;
    tick();
    wr0_en     = 1'b0;
    mbank[idx] = data;
  endtask

  // Full read on DUT0: optional same-edge bank write, optional R stall cycles.
  task automatic axi_read(input logic [31:0] addr, input int stall,
                          input logic coll, input logic [2:0] cidx,
                          input logic [31:0] cdata);
    exp_t e;
    int   n;
    logic err;
    err    = (addr[1:0] != 2'b00) || (addr[31:5] != 27'd0);
    e.resp = err ? RESP_SLVERR : RESP_OKAY;
    e.data = err ? 32'd0 : mbank[addr[4:2]];
    sb.push_back(e);
    n = 0;
    while (m0.ARREADY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (m0.ARREADY !== 1'b1) begin
      failures++;
      $display("FAIL arready_wait addr=%h got=%b exp=1", addr, m0.ARREADY);
    end
    m0.ARVALID = 1'b1;
    m0.ARADDR  = addr;
    m0.ARPROT  = 3'b000;
    m0.RREADY  = (stall == 0);
    if (coll) begin
      wr0_en   = 1'b1;
      wr0_idx  = cidx;
      wr0_data = cdata;
    end
    tick();
    if (coll) begin
      wr0_en      = 1'b0;
      mbank[cidx] = cdata;
    end
    m0.ARVALID = 1'b0;
    m0.ARADDR  = $urandom;
    e = sb.pop_front();
    checks++;
    if (m0.ARREADY !== 1'b0 || m0.RVALID !== 1'b1) begin
      failures++;
      $display("FAIL ar_to_r addr=%h arready=%b rvalid=%b exp 0/1", addr, m0.ARREADY, m0.RVALID);
    end
    checks++;
    if (m0.RDATA !== e.data) begin
      failures++;
      $display("FAIL rdata addr=%h got=%h exp=%h", addr, m0.RDATA, e.data);
    end
    checks++;
    if (m0.RRESP !== e.resp) begin
      failures++;
      $display("FAIL rresp addr=%h got=%b exp=%b", addr, m0.RRESP, e.resp);
    end
    for (int i = 0; i < stall; i++) begin
      if (i == 0) begin
        wr0_en   = 1'b1;
        wr0_idx  = addr[4:2];
        wr0_data = ~mbank[addr[4:2]];
      end
      tick();
      if (i == 0) begin
        wr0_en           = 1'b0;
        mbank[addr[4:2]] = wr0_data;
      end
      checks++;
      if (m0.RVALID !== 1'b1 || m0.ARREADY !== 1'b0 || m0.RDATA !== e.data || m0.RRESP !== e.resp) begin
        failures++;
        $display("FAIL hold cyc=%0d rvalid=%b arready=%b rdata=%h rresp=%b exp 1/0/%h/%b",
                 i, m0.RVALID, m0.ARREADY, m0.RDATA, m0.RRESP, e.data, e.resp);
      end
    end
    m0.RREADY = 1'b1;
    tick();
    exp_count++;
    m0.RREADY = 1'b0;
    checks++;
    if (m0.RVALID !== 1'b0 || m0.ARREADY !== 1'b1) begin
      failures++;
      $display("FAIL complete rvalid=%b arready=%b exp 0/1", m0.RVALID, m0.ARREADY);
    end
    checks++;
    if (rd0_count !== exp_count[15:0]) begin
      failures++;
      $display("FAIL rd_count got=%0d exp=%0d", rd0_count, exp_count);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    #1;
    checks++;
    if (m0.ARREADY !== 1'b0 || m0.RVALID !== 1'b0 || m0.RDATA !== 32'd0 ||
        m0.RRESP !== 2'b00 || rd0_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_vals arready=%b rvalid=%b rdata=%h rresp=%b cnt=%0d exp all 0",
               m0.ARREADY, m0.RVALID, m0.RDATA, m0.RRESP, rd0_count);
    end
    tick();
    tick();
    checks++;
    if (m0.ARREADY !== 1'b0) begin
      failures++;
      $display("FAIL arready_in_reset got=%b exp=0", m0.ARREADY);
    end
    ARESET = 1'b0;
    #1;
    checks++;
    if (m0.ARREADY !== 1'b0) begin
      failures++;
      $display("FAIL arready_pre_edge got=%b exp=0", m0.ARREADY);
    end
    tick();
    checks++;
    if (m0.ARREADY !== 1'b1) begin
      failures++;
      $display("FAIL arready_after_release got=%b exp=1", m0.ARREADY);
    end
  endtask

  task automatic test_basic();
    bank_write(3'd2, 32'hDEADBEEF);
    axi_read(32'h8, 0, 1'b0, 3'd0, 32'd0);
    axi_read(32'h8, 5, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic test_errors();
    bank_write(3'd7, 32'h7777_0007);
    axi_read(32'h6, 0, 1'b0, 3'd0, 32'd0);
    axi_read(32'h20, 0, 1'b0, 3'd0, 32'd0);
    axi_read(32'h1C, 0, 1'b0, 3'd0, 32'd0);
    axi_read(32'h8000_0009, 2, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic test_back_to_back();
    bank_write(3'd5, 32'h5555_AAAA);
    axi_read(32'h14, 0, 1'b0, 3'd0, 32'd0);
    axi_read(32'h0, 0, 1'b0, 3'd0, 32'd0);
    axi_read(32'h14, 1, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic test_collision();
    bank_write(3'd1, 32'hAAAA);
    axi_read(32'h4, 0, 1'b1, 3'd1, 32'h1234);
    axi_read(32'h4, 0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic test_priv();
    exp_t        e;
    logic [2:0]  prot;
    logic [15:0] cnt;
    wr1_en   = 1'b1;
    wr1_idx  = 3'd0;
    wr1_data = 32'hC0FFEE01;
    tick();
    wr1_en = 1'b0;
    cnt    = rd1_count;
    for (int k = 0; k < 2; k++) begin
      prot   = (k == 0) ? 3'b000 : 3'b001;
      e.resp = (k == 0) ? RESP_SLVERR : RESP_OKAY;
      e.data = (k == 0) ? 32'd0 : 32'hC0FFEE01;
      sb.push_back(e);
      m1.ARVALID = 1'b1;
      m1.ARADDR  = 32'h0;
      m1.ARPROT  = prot;
      m1.RREADY  = 1'b1;
      tick();
      m1.ARVALID = 1'b0;
      e = sb.pop_front();
      checks++;
      if (m1.RVALID !== 1'b1 || m1.RRESP !== e.resp || m1.RDATA !== e.data) begin
        failures++;
        $display("FAIL priv prot=%b rvalid=%b rresp=%b rdata=%h exp 1/%b/%h",
                 prot, m1.RVALID, m1.RRESP, m1.RDATA, e.resp, e.data);
      end
      tick();
      m1.RREADY = 1'b0;
      cnt       = cnt + 16'd1;
      checks++;
      if (m1.RVALID !== 1'b0 || rd1_count !== cnt) begin
        failures++;
        $display("FAIL priv_done rvalid=%b cnt=%0d exp 0/%0d", m1.RVALID, rd1_count, cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (m0.ARREADY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    m0.ARVALID = 1'b1;
    m0.ARADDR  = 32'h8;
    m0.RREADY  = 1'b0;
    tick();
    m0.ARVALID = 1'b0;
    checks++;
    if (m0.RVALID !== 1'b1) begin
      failures++;
      $display("FAIL mid_rvalid got=%b exp=1", m0.RVALID);
    end
    #2;
    ARESET = 1'b1;
    #1;
    checks++;
    if (m0.RVALID !== 1'b0 || m0.ARREADY !== 1'b0 || rd0_count !== 16'd0 || m0.RDATA !== 32'd0) begin
      failures++;
      $display("FAIL async_clear rvalid=%b arready=%b cnt=%0d rdata=%h exp 0/0/0/0",
               m0.RVALID, m0.ARREADY, rd0_count, m0.RDATA);
    end
    for (int i = 0; i < 8; i++) mbank[i] = 32'd0;
    exp_count = 0;
    tick();
    ARESET = 1'b0;
    tick();
    checks++;
    if (m0.ARREADY !== 1'b1) begin
      failures++;
      $display("FAIL arready_post_reset got=%b exp=1", m0.ARREADY);
    end
    axi_read(32'h8, 0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_count  = 0;
    wr0_en     = 1'b0;
    wr0_idx    = 3'd0;
    wr0_data   = 32'd0;
    wr1_en     = 1'b0;
    wr1_idx    = 3'd0;
    wr1_data   = 32'd0;
    m0.ARVALID = 1'b0;
    m0.ARADDR  = 32'd0;
    m0.ARPROT  = 3'b000;
    m0.RREADY  = 1'b0;
    m1.ARVALID = 1'b0;
    m1.ARADDR  = 32'd0;
    m1.ARPROT  = 3'b000;
    m1.RREADY  = 1'b0;
    for (int i = 0; i < 8; i++) mbank[i] = 32'd0;
    test_reset();
    test_basic();
    test_errors();
    test_back_to_back();
    test_collision();
    test_priv();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
